// File: rtl/demux4_pkg.sv
// Shared constants for the 1-to-4 stream demultiplexer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package demux4_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    localparam int CH_A = 0;
    localparam int CH_B = 1;
    localparam int CH_C = 2;
    localparam int CH_D = 3;

    // Bit offset of channel ch inside a flat bus of per-channel fields of width w.
    function automatic int ch_off(input int ch, input int w);
        return ch * w;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry registered holding slot with a saturating accept counter.
// Latency: a word written at an edge is presented on valid/data the next cycle.
// Backpressure: can_accept = empty or draining this cycle; data is frozen while full and stalled.
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset (clears valid, data, count)
//   wr_en        write wr_data into the slot this edge (caller guarantees can_accept)
//   wr_data      word to store
//   rd_ready     consumer accepts the held word this edge
//   clr          synchronous counter clear, wins over a same-edge increment
//   valid/data   held word and its valid flag
//   count        saturating count of writes
//   can_accept   slot can take a word this edge
module demux_slot #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    input  logic             clr,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] count,
    output logic             can_accept
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Drain and refill can happen on the same edge, so a ready consumer frees the slot.
    assign can_accept = ~valid_q | rd_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        count_d = count_q;

        if (wr_en) begin
            valid_d = 1'b1;
            data_d  = wr_data;
        end else if (valid_q && rd_ready) begin
            // Data is left as-is when the slot empties; only the flag drops.
            valid_d = 1'b0;
        end

        if (clr) begin
            count_d = '0;
        end else if (wr_en && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign count = count_q;

endmodule

// File: rtl/demux4_stream.sv
// 1-to-4 valid/ready stream demultiplexer with per-channel registered slots and counters.
// Latency: one cycle from accept to out_valid[k]; 1 word/cycle into a channel whose out_ready is high.
// Backpressure: in_ready follows only the selected channel; a full stalled target blocks the input (no reordering).
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   in_data/in_sel    input word and destination channel (0=a .. 3=d), qualified by in_valid
//   in_ready          combinational: selected slot empty or draining
//   out_data          channel k word at [k*WIDTH +: WIDTH]
//   out_valid/ready   per-channel handshake, bit k = channel k
//   clr_cnt           clear all counters
//   cnt               channel k accept count at [k*CNT_W +: CNT_W]
module demux4_stream
    import demux4_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [NUM_CH*WIDTH-1:0] out_data,
    output logic [NUM_CH-1:0]       out_valid,
    input  logic [NUM_CH-1:0]       out_ready,
    input  logic                    clr_cnt,
    output logic [NUM_CH*CNT_W-1:0] cnt
);

    logic [NUM_CH-1:0] can_acc;
    logic [NUM_CH-1:0] wr_en;
    logic              accept;

    assign in_ready = can_acc[in_sel];
    assign accept   = in_valid & in_ready;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign wr_en[k] = accept && (in_sel == SEL_W'(k));

        demux_slot #(
            .WIDTH (WIDTH),
            .CNT_W (CNT_W)
        ) u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .wr_en      (wr_en[k]),
            .wr_data    (in_data),
            .rd_ready   (out_ready[k]),
            .clr        (clr_cnt),
            .valid      (out_valid[k]),
            .data       (out_data[ch_off(k, WIDTH) +: WIDTH]),
            .count      (cnt[ch_off(k, CNT_W) +: CNT_W]),
            .can_accept (can_acc[k])
        );
    end

endmodule

// File: tb/tb_demux4_stream.sv
// Self-checking bench for demux4_stream: directed scenarios plus randomized traffic
// compared every cycle against a per-channel behavioural model.
module tb_demux4_stream;

    localparam int W  = 4;
    localparam int CW = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  in_data;
    logic [1:0]    in_sel;
    logic          in_valid;
    logic          in_ready;
    logic [4*W-1:0]  out_data;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic          clr_cnt;
    logic [4*CW-1:0] cnt;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Behavioural model: what each channel holds and how many words it has taken.
    bit         m_vld [4];
    logic [W-1:0] m_dat [4];
    int         m_cnt [4];

    demux4_stream #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .clr_cnt   (clr_cnt),
        .cnt       (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model update: apply the handshake rules at every rising edge.
    always @(posedge clk) begin
        bit acc;
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                m_vld[k] = 1'b0;
                m_dat[k] = '0;
                m_cnt[k] = 0;
            end
        end else begin
            acc = in_valid && (!m_vld[in_sel] || out_ready[in_sel]);
            for (int k = 0; k < 4; k++) begin
                if (acc && (int'(in_sel) == k)) begin
                    m_vld[k] = 1'b1;
                    m_dat[k] = in_data;
                end else if (out_ready[k]) begin
                    m_vld[k] = 1'b0;
                end
            end
            if (clr_cnt) begin
                for (int k = 0; k < 4; k++) m_cnt[k] = 0;
            end else if (acc && m_cnt[in_sel] < CMAX) begin
                m_cnt[in_sel] = m_cnt[in_sel] + 1;
            end
        end
    end

    // Per-cycle comparison, well away from the rising edge.
    always @(negedge clk) begin
        logic [3:0]     e_vld;
        logic [4*W-1:0] e_dat;
        logic [4*CW-1:0] e_cnt;
        if (chk_en) begin
            #2;
            for (int k = 0; k < 4; k++) begin
                e_vld[k]         = m_vld[k];
                e_dat[k*W +: W]  = m_dat[k];
                e_cnt[k*CW +: CW] = CW'(m_cnt[k]);
            end
            chk("model_out_valid", 32'(out_valid), 32'(e_vld));
            chk("model_out_data",  32'(out_data),  32'(e_dat));
            chk("model_cnt",       32'(cnt),       32'(e_cnt));
            if (rst_n)
                chk("model_in_ready", 32'(in_ready),
                    32'(!m_vld[in_sel] || out_ready[in_sel]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with a pending word on the input: nothing may be accepted.
        rst_n = 1'b0; in_valid = 1'b1; in_sel = 2'd2; in_data = 4'hF;
        out_ready = 4'hF; clr_cnt = 1'b0;
        step(); step();
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data",  32'(out_data),  32'h0);
        chk("rst_cnt",       32'(cnt),       32'h0);
        chk_en = 1'b1;
        rst_n = 1'b1; in_valid = 1'b0;
        step();
        chk("post_rst_idle", 32'(out_valid), 32'h0);

        // Routing sweep: each word lands only on its own channel one cycle later.
        out_ready = 4'hF;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_sel = 2'(i); in_data = 4'(i + 1);
            #1;
            chk("sweep_in_ready", 32'(in_ready), 32'h1);
            step();
            chk("sweep_valid", 32'(out_valid), 32'(4'b1 << i));
            chk("sweep_data",  32'(out_data[i*W +: W]), 32'(i + 1));
        end
        in_valid = 1'b0;
        chk("sweep_cnt", 32'(cnt), 32'h55);

        // Backpressure on channel b.
        out_ready = 4'b1101; in_valid = 1'b1; in_sel = 2'd1; in_data = 4'hA;
        step();
        in_data = 4'hB;
        #1;
        chk("bp_in_ready_lo", 32'(in_ready), 32'h0);
        step();
        chk("bp_hold_data", 32'(out_data[W +: W]), 32'hA);
        chk("bp_hold_vld",  32'(out_valid[1]), 32'h1);
        out_ready = 4'hF;
        #1;
        chk("bp_in_ready_hi", 32'(in_ready), 32'h1);
        step();
        chk("bp_refill_vld",  32'(out_valid[1]), 32'h1);
        chk("bp_refill_data", 32'(out_data[W +: W]), 32'hB);

        // Head-of-line: b stalled blocks input while d drains independently.
        out_ready = 4'b0101; in_sel = 2'd3; in_data = 4'h9;
        step();
        chk("hol_d_loaded", 32'(out_valid[3]), 32'h1);
        out_ready = 4'b1001; in_sel = 2'd1; in_data = 4'hC;
        #1;
        chk("hol_in_ready", 32'(in_ready), 32'h0);
        step();
        chk("hol_d_drained", 32'(out_valid[3]), 32'h0);
        chk("hol_b_held",    32'(out_data[W +: W]), 32'hB);
        in_sel = 2'd3;
        #1;
        chk("hol_switch_rdy", 32'(in_ready), 32'h1);
        step();
        chk("hol_d_new", 32'(out_data[3*W +: W]), 32'hC);

        // Counter saturation and clear on channel c.
        out_ready = 4'hF; in_sel = 2'd2;
        for (int i = 0; i < 5; i++) begin
            in_data = 4'(i);
            step();
        end
        chk("sat_cnt_c",   32'(cnt[2*CW +: CW]), 32'h3);
        chk("sat_model_c", 32'(m_cnt[2]), 32'h3);
        clr_cnt = 1'b1; in_data = 4'hE;
        step();
        clr_cnt = 1'b0; in_valid = 1'b0;
        chk("clr_cnt_all", 32'(cnt), 32'h0);
        chk("clr_word",    32'(out_data[2*W +: W]), 32'hE);
        chk("clr_vld",     32'(out_valid[2]), 32'h1);

        // Reset while channel a holds a stalled word.
        out_ready = 4'h0; in_valid = 1'b1; in_sel = 2'd0; in_data = 4'h7;
        step();
        in_valid = 1'b0;
        chk("mid_a_held", 32'(out_data[W-1:0]), 32'h7);
        rst_n = 1'b0;
        step();
        chk("mid_rst_vld",  32'(out_valid), 32'h0);
        chk("mid_rst_data", 32'(out_data[W-1:0]), 32'h0);
        rst_n = 1'b1; out_ready = 4'hF;
        step();
        chk("mid_no_deliver", 32'(out_valid[0]), 32'h0);

        // Randomized traffic, checked every cycle against the model.
        for (int n = 0; n < 3000; n++) begin
            rst_n     = ($urandom_range(0, 299) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sel    = 2'($urandom_range(0, 3));
            in_data   = 4'($urandom);
            out_ready = 4'($urandom) | 4'($urandom);
            if ($urandom_range(0, 4) == 0) out_ready = 4'h0;
            clr_cnt   = ($urandom_range(0, 39) == 0);
            step();
        end
        rst_n = 1'b1; in_valid = 1'b0; clr_cnt = 1'b0;
        step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
